// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - pipeline controller state encodings and control words
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HAZARD   = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_bubble;
        logic back_en;
    } pipe_ctrl_t;

    // Reset loads NOPs into both front registers while everything is held
    localparam pipe_ctrl_t CTRL_RESET      = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1, back_en: 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE     = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0, back_en: 1'b0};
    localparam pipe_ctrl_t CTRL_FLUSH      = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0, back_en: 1'b1};
    localparam pipe_ctrl_t CTRL_BUBBLE     = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1, back_en: 1'b1};
    localparam pipe_ctrl_t CTRL_FETCH_MISS = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0, back_en: 1'b1};
    localparam pipe_ctrl_t CTRL_NORMAL     = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0, back_en: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard/memory status in, pipeline enables out
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
    logic             hazard_stall_in;
    logic             branch_taken_in;
    logic             imem_ready_in;
    logic             dmem_req_in;
    logic             dmem_ready_in;
    logic             pc_en_out;
    logic             ifid_en_out;
    logic             ifid_flush_out;
    logic             idex_bubble_out;
    logic             back_en_out;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] stall_count_out;
    logic             deadlock_out;

    modport master (
        output hazard_stall_in, branch_taken_in, imem_ready_in, dmem_req_in, dmem_ready_in,
        input  pc_en_out, ifid_en_out, ifid_flush_out, idex_bubble_out, back_en_out,
        input  state_out, stall_count_out, deadlock_out
    );

    modport slave (
        input  hazard_stall_in, branch_taken_in, imem_ready_in, dmem_req_in, dmem_ready_in,
        output pc_en_out, ifid_en_out, ifid_flush_out, idex_bubble_out, back_en_out,
        output state_out, stall_count_out, deadlock_out
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(negedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline stall/flush/freeze controller
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_LIMIT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
    pipeline_ctrl_if.slave  bus
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] HZ_LIMIT     = 8'(STALL_LIMIT);

    pipe_state_t state, state_nx;
    logic [2:0]  flush_cnt, flush_nx;
    logic [7:0]  hz_cnt, hz_nx;
    logic        deadlock, dead_nx;
    logic        memwait, flushing;
    pipe_ctrl_t  ctrl;

    assign memwait  = bus.dmem_req_in & ~bus.dmem_ready_in;
    // flush_cnt survives a memwait freeze, so a pending flush resumes afterwards
    assign flushing = bus.branch_taken_in | (flush_cnt != 3'd0);

    always_ff @(negedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
            hz_cnt    <= 8'd0;
            deadlock  <= 1'b0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_nx;
            hz_cnt    <= hz_nx;
            deadlock  <= dead_nx;
        end
    end

    always_comb begin
        state_nx = ST_RUN;
        flush_nx = flush_cnt;
        hz_nx    = hz_cnt;
        dead_nx  = deadlock;
        if (memwait) begin
            state_nx = ST_MEM_WAIT;
        end else begin
            if (!bus.hazard_stall_in) begin
                hz_nx = 8'd0;
            end
            if (flushing) begin
                flush_nx = bus.branch_taken_in ? FLUSH_RELOAD : flush_cnt - 3'd1;
                state_nx = (flush_nx != 3'd0) ? ST_FLUSH : ST_RUN;
            end else if (bus.hazard_stall_in) begin
                state_nx = ST_HAZARD;
                if (hz_cnt != HZ_LIMIT) begin
                    hz_nx = hz_cnt + 8'd1;
                end
                if (hz_nx == HZ_LIMIT) begin
                    dead_nx = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ctrl = CTRL_NORMAL;
        if (!reset) begin
            ctrl = CTRL_RESET;
        end else if (memwait) begin
            ctrl = CTRL_FREEZE;
        end else if (flushing) begin
            ctrl = CTRL_FLUSH;
        end else if (bus.hazard_stall_in) begin
            ctrl = CTRL_BUBBLE;
        end else if (!bus.imem_ready_in) begin
            ctrl = CTRL_FETCH_MISS;
        end
    end

    assign bus.pc_en_out       = ctrl.pc_en;
    assign bus.ifid_en_out     = ctrl.ifid_en;
    assign bus.ifid_flush_out  = ctrl.ifid_flush;
    assign bus.idex_bubble_out = ctrl.idex_bubble;
    assign bus.back_en_out     = ctrl.back_en;
    assign bus.state_out       = state;
    assign bus.deadlock_out    = deadlock;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .inc   (~ctrl.pc_en),
        .clear (~reset),
        .count (bus.stall_count_out)
    );

endmodule
